// File: rtl/get_reg.sv
// get_reg: RISC-V GPR name lookup for trace / register-dump output.
//
// Translates a GPR index to its ABI mnemonic (packed ASCII, right-justified,
// last character in bits [7:0], unused leading bytes 0x00). It also translates
// a mnemonic back to an index. Both lookups run on every request. Only
// debug/printing logic uses this block; it holds no architectural state.
//
// Ports:
//   clk          in   rising-edge clock
//   reset        in   synchronous, active-high; clears registered outputs
//   req_valid    in   lookup request strobe
//   req_idx      in   [5:0]  register index to name
//   req_name     in   [31:0] packed ASCII mnemonic to index
//   name_comb    out  [31:0] combinational name of req_idx
//   rsp_valid    out  registered copy of req_valid
//   rsp_name     out  [31:0] registered name of req_idx
//   rsp_in_range out  req_idx was 0..31
//   rsp_idx      out  [4:0]  registered index of req_name (0 on miss)
//   rsp_hit      out  req_name matched a known mnemonic
module get_reg (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic [5:0]  req_idx,
    input  logic [31:0] req_name,
    output logic [31:0] name_comb,
    output logic        rsp_valid,
    output logic [31:0] rsp_name,
    output logic        rsp_in_range,
    output logic [4:0]  rsp_idx,
    output logic        rsp_hit
);

    // Mnemonic table. Short names are zero-padded on the left so that
    // printing with %0s shows no padding. Indices 32..63 give 0.
    function automatic logic [31:0] name_of(input logic [5:0] idx);
        logic [31:0] n;
        n = 32'h0;
        case (idx)
            6'd0:  n = "zero";
            6'd1:  n = {16'h0, "ra"};
            6'd2:  n = {16'h0, "sp"};
            6'd3:  n = {16'h0, "gp"};
            6'd4:  n = {16'h0, "tp"};
            6'd5:  n = {16'h0, "t0"};
            6'd6:  n = {16'h0, "t1"};
            6'd7:  n = {16'h0, "t2"};
            6'd8:  n = {16'h0, "s0"};
            6'd9:  n = {16'h0, "s1"};
            6'd10: n = {16'h0, "a0"};
            6'd11: n = {16'h0, "a1"};
            6'd12: n = {16'h0, "a2"};
            6'd13: n = {16'h0, "a3"};
            6'd14: n = {16'h0, "a4"};
            6'd15: n = {16'h0, "a5"};
            6'd16: n = {16'h0, "a6"};
            6'd17: n = {16'h0, "a7"};
            6'd18: n = {16'h0, "s2"};
            6'd19: n = {16'h0, "s3"};
            6'd20: n = {16'h0, "s4"};
            6'd21: n = {16'h0, "s5"};
            6'd22: n = {16'h0, "s6"};
            6'd23: n = {16'h0, "s7"};
            6'd24: n = {16'h0, "s8"};
            6'd25: n = {16'h0, "s9"};
            6'd26: n = {8'h0, "s10"};
            6'd27: n = {8'h0, "s11"};
            6'd28: n = {16'h0, "t3"};
            6'd29: n = {16'h0, "t4"};
            6'd30: n = {16'h0, "t5"};
            6'd31: n = {16'h0, "t6"};
            default: n = 32'h0;
        endcase
        return n;
    endfunction

    logic [31:0] name_d, name_q;
    logic        in_range_d, in_range_q;
    logic [4:0]  idx_d, idx_q;
    logic        hit_d, hit_q;
    logic        valid_q;

    assign name_d     = name_of(req_idx);
    assign in_range_d = ~req_idx[5];
    assign name_comb  = name_d;

    // Reverse lookup: exact 32-bit compare against every table entry.
    // The table entries are all distinct, so at most one entry matches.
    // "fp" is an alias for s0.
    always_comb begin
        hit_d = 1'b0;
        idx_d = 5'd0;
        for (int i = 0; i < 32; i++) begin
            if (req_name == name_of(6'(i))) begin
                hit_d = 1'b1;
                idx_d = 5'(i);
            end
        end
        if (req_name == {16'h0, "fp"}) begin
            hit_d = 1'b1;
            idx_d = 5'd8;
        end
    end

    // Data registers load only on a request and hold otherwise; valid
    // tracks req_valid every cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q    <= 1'b0;
            name_q     <= 32'h0;
            in_range_q <= 1'b0;
            idx_q      <= 5'd0;
            hit_q      <= 1'b0;
        end else begin
            valid_q <= req_valid;
            if (req_valid) begin
                name_q     <= name_d;
                in_range_q <= in_range_d;
                idx_q      <= idx_d;
                hit_q      <= hit_d;
            end
        end
    end

    assign rsp_valid    = valid_q;
    assign rsp_name     = name_q;
    assign rsp_in_range = in_range_q;
    assign rsp_idx      = idx_q;
    assign rsp_hit      = hit_q;

endmodule

// File: tb/tb_get_reg.sv
module tb_get_reg;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic [5:0]  req_idx;
    logic [31:0] req_name;
    logic [31:0] name_comb;
    logic        rsp_valid;
    logic [31:0] rsp_name;
    logic        rsp_in_range;
    logic [4:0]  rsp_idx;
    logic        rsp_hit;

    get_reg dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_idx(req_idx),
        .req_name(req_name), .name_comb(name_comb), .rsp_valid(rsp_valid),
        .rsp_name(rsp_name), .rsp_in_range(rsp_in_range), .rsp_idx(rsp_idx),
        .rsp_hit(rsp_hit)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        v;
        logic [31:0] name;
        logic        inr;
        logic [4:0]  idx;
        logic        hit;
    } rsp_t;

    rsp_t sb[$];
    rsp_t held;
    int   passed = 0;
    int   total  = 0;

    // Expected names as raw hex, written out independently of the RTL table.
    logic [31:0] ref_names [32] = '{
        32'h7A65726F, 32'h00007261, 32'h00007370, 32'h00006770,
        32'h00007470, 32'h00007430, 32'h00007431, 32'h00007432,
        32'h00007330, 32'h00007331, 32'h00006130, 32'h00006131,
        32'h00006132, 32'h00006133, 32'h00006134, 32'h00006135,
        32'h00006136, 32'h00006137, 32'h00007332, 32'h00007333,
        32'h00007334, 32'h00007335, 32'h00007336, 32'h00007337,
        32'h00007338, 32'h00007339, 32'h00733130, 32'h00733131,
        32'h00007433, 32'h00007434, 32'h00007435, 32'h00007436
    };

    function automatic logic [31:0] ref_name(input logic [5:0] i);
        return (i < 6'd32) ? ref_names[i[4:0]] : 32'h0;
    endfunction

    // Returns {hit, idx}
    function automatic logic [5:0] ref_lookup(input logic [31:0] n);
        logic [5:0] r;
        r = 6'd0;
        if (n == 32'h00006670) r = {1'b1, 5'd8};
        for (int i = 0; i < 32; i++)
            if (n == ref_names[i]) r = {1'b1, 5'(i)};
        return r;
    endfunction

    // Model the next registered response from the currently driven inputs.
    task automatic push_exp();
        rsp_t e;
        logic [5:0] lk;
        if (reset) begin
            held = '0;
            e    = '0;
        end else begin
            if (req_valid) begin
                lk = ref_lookup(req_name);
                held.name = ref_name(req_idx);
                held.inr  = (req_idx < 6'd32);
                held.idx  = lk[4:0];
                held.hit  = lk[5];
            end
            e   = held;
            e.v = req_valid;
        end
        sb.push_back(e);
    endtask

    function automatic rsp_t got_rsp();
        return '{rsp_valid, rsp_name, rsp_in_range, rsp_idx, rsp_hit};
    endfunction

    task automatic test_reset();
        rsp_t e, g;
        reset = 1'b1; req_valid = 1'b1; req_idx = 6'd5; req_name = 32'h00006130;
        #1;
        total++;
        if (name_comb !== 32'h00007430)
            $display("FAIL reset_name_comb got=%h want=%h", name_comb, 32'h00007430);
        else passed++;
        push_exp();
        @(posedge clk); #1;
        e = sb.pop_front(); g = got_rsp();
        total++;
        if (g !== e) $display("FAIL reset_outputs got=%h want=%h", g, e);
        else passed++;
        reset = 1'b0;
    endtask

    task automatic test_sweep();
        rsp_t e, g;
        for (int i = 0; i < 32; i++) begin
            req_valid = 1'b1; req_idx = 6'(i); req_name = 32'h0;
            #1;
            total++;
            if (name_comb !== ref_name(6'(i)))
                $display("FAIL sweep_comb idx=%0d got=%h want=%h", i, name_comb, ref_name(6'(i)));
            else passed++;
            push_exp();
            @(posedge clk); #1;
            e = sb.pop_front(); g = got_rsp();
            total++;
            if (g !== e) $display("FAIL sweep_rsp idx=%0d got=%h want=%h", i, g, e);
            else passed++;
        end
    endtask

    task automatic test_out_of_range();
        rsp_t e, g;
        logic [5:0] ids [3] = '{6'd40, 6'd32, 6'd63};
        for (int k = 0; k < 3; k++) begin
            req_valid = 1'b1; req_idx = ids[k]; req_name = 32'h0;
            #1;
            total++;
            if (name_comb !== 32'h0)
                $display("FAIL oor_comb idx=%0d got=%h want=0", ids[k], name_comb);
            else passed++;
            push_exp();
            @(posedge clk); #1;
            e = sb.pop_front(); g = got_rsp();
            total++;
            if (g !== e) $display("FAIL oor_rsp idx=%0d got=%h want=%h", ids[k], g, e);
            else passed++;
        end
    endtask

    task automatic test_name_lookup();
        rsp_t e, g;
        logic [31:0] names [7] = '{32'h00006130, 32'h00006670, 32'h00007837,
                                   32'h72610000, 32'h7A65726F, 32'h00005241,
                                   32'h00733131};
        // Back-to-back: responses pop one per cycle while requests stream.
        for (int k = 0; k < 7; k++) begin
            req_valid = 1'b1; req_idx = 6'(k + 3); req_name = names[k];
            push_exp();
            @(posedge clk); #1;
            e = sb.pop_front(); g = got_rsp();
            total++;
            if (g !== e) $display("FAIL name_lookup name=%h got=%h want=%h", names[k], g, e);
            else passed++;
        end
    endtask

    task automatic test_hold();
        rsp_t e, g;
        req_valid = 1'b1; req_idx = 6'd2; req_name = 32'h00006670;
        push_exp();
        @(posedge clk); #1;
        e = sb.pop_front(); g = got_rsp();
        total++;
        if (g !== e) $display("FAIL hold_load got=%h want=%h", g, e);
        else passed++;
        for (int k = 0; k < 3; k++) begin
            req_valid = 1'b0; req_idx = 6'(7 + 9 * k); req_name = 32'h00006137;
            #1;
            total++;
            if (name_comb !== ref_name(req_idx))
                $display("FAIL hold_comb idx=%0d got=%h want=%h", req_idx, name_comb, ref_name(req_idx));
            else passed++;
            push_exp();
            @(posedge clk); #1;
            e = sb.pop_front(); g = got_rsp();
            total++;
            if (g !== e || rsp_name !== 32'h00007370)
                $display("FAIL hold_rsp cyc=%0d got=%h want=%h", k, g, e);
            else passed++;
        end
    endtask

    task automatic test_reset_midstream();
        rsp_t e, g;
        req_valid = 1'b1; req_idx = 6'd20; req_name = 32'h00007433;
        push_exp();
        @(posedge clk); #1;
        e = sb.pop_front(); g = got_rsp();
        total++;
        if (g !== e) $display("FAIL mid_pre got=%h want=%h", g, e);
        else passed++;
        reset = 1'b1; req_valid = 1'b1; req_idx = 6'd5; req_name = 32'h00006130;
        push_exp();
        @(posedge clk); #1;
        e = sb.pop_front(); g = got_rsp();
        total++;
        if (g !== e) $display("FAIL mid_reset got=%h want=%h", g, e);
        else passed++;
        reset = 1'b0; req_valid = 1'b1; req_idx = 6'd1; req_name = 32'h0;
        push_exp();
        @(posedge clk); #1;
        e = sb.pop_front(); g = got_rsp();
        total++;
        if (g !== e || rsp_name !== 32'h00007261)
            $display("FAIL mid_after got=%h want=%h", g, e);
        else passed++;
    endtask

    task automatic test_round_trip();
        rsp_t e, g;
        for (int i = 0; i < 32; i++) begin
            req_valid = 1'b1; req_idx = 6'(i); req_name = 32'h0;
            push_exp();
            @(posedge clk); #1;
            void'(sb.pop_front());
            // Feed the produced name back; the expected index is i itself.
            req_name = rsp_name;
            push_exp();
            @(posedge clk); #1;
            e = sb.pop_front(); g = got_rsp();
            total++;
            if (g !== e || rsp_idx !== 5'(i) || rsp_hit !== 1'b1)
                $display("FAIL round_trip i=%0d got_idx=%0d got_hit=%b want_idx=%0d want_hit=1",
                         i, rsp_idx, rsp_hit, i);
            else passed++;
        end
    endtask

    initial begin
        held = '0;
        reset = 1'b1; req_valid = 1'b0; req_idx = '0; req_name = '0;
        @(negedge clk);
        test_reset();
        test_sweep();
        test_out_of_range();
        test_name_lookup();
        test_hold();
        test_reset_midstream();
        test_round_trip();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
